// File: rtl/key_event.sv
// -----------------------------------------------------------------------------
// key_event
//
// Classifies debounced key gestures into short press, long press and double
// click. Each event comes out as a one-cycle registered pulse. A registered
// "key held" level is also provided.
//
// Optional feature macro: KEY_EVENT_REPEAT_EN
//   When defined, adds the repeat_press output. It pulses every REPEAT_CNT
//   cycles while the key stays held after a long press.
//
// Parameters:
//   LONG_CNT   - cycles a press must be held to count as a long press
//   DCLICK_CNT - max cycles from release to second press for a double click
//   REPEAT_CNT - auto-repeat period in HELD (only used with KEY_EVENT_REPEAT_EN)
//   CNT_W      - width of the internal cycle counter
//
// Ports:
//   clk          - system clock
//   rst          - asynchronous, active-high reset
//   key_flag     - one-cycle strobe from the debouncer: key_state changed
//   key_state    - debounced level, 0 = pressed, 1 = released
//   short_press  - pulse: single short press completed
//   long_press   - pulse: press held LONG_CNT cycles
//   double_click - pulse: second press released inside the window
//   key_held     - level: 1 while the key is pressed
//   repeat_press - pulse: auto-repeat while held (KEY_EVENT_REPEAT_EN only)
// -----------------------------------------------------------------------------
module key_event #(
    parameter int unsigned LONG_CNT   = 32'd50_000_000,
    parameter int unsigned DCLICK_CNT = 32'd15_000_000,
    parameter int unsigned REPEAT_CNT = 32'd10_000_000,
    parameter int unsigned CNT_W      = 32'd26
) (
    input  logic clk,
    input  logic rst,
    input  logic key_flag,
    input  logic key_state,
    output logic short_press,
    output logic long_press,
    output logic double_click,
`ifdef KEY_EVENT_REPEAT_EN
    output logic repeat_press,
`endif
    output logic key_held
);

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_PRESS1 = 5'b00010,
        ST_HELD   = 5'b00100,
        ST_WAIT2  = 5'b01000,
        ST_PRESS2 = 5'b10000
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 32'd1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CNT - 32'd1);
    localparam longint unsigned  CNT_LIM     = 64'd1 << CNT_W;

    // The compare values must fit the counter, otherwise a threshold is never reached.
    if ((64'(LONG_CNT) < 64'd2) || (64'(LONG_CNT) >= CNT_LIM) ||
        (64'(DCLICK_CNT) < 64'd2) || (64'(DCLICK_CNT) >= CNT_LIM) ||
        (64'(REPEAT_CNT) < 64'd2) || (64'(REPEAT_CNT) >= CNT_LIM)) begin : g_param_check
        $error("key_event: LONG_CNT, DCLICK_CNT, REPEAT_CNT must be >= 2 and < 2**CNT_W");
    end

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             cnt_clr_s;
    logic             press_ev_s;
    logic             release_ev_s;
    logic             short_nxt_s;
    logic             long_nxt_s;
    logic             dbl_nxt_s;

`ifdef KEY_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 32'd1);
    logic rep_nxt_s;
    logic rep_clr_s;
`endif

    assign press_ev_s   = key_flag & ~key_state;
    assign release_ev_s = key_flag &  key_state;

    // The counter restarts on every state change. With auto-repeat it also restarts at each repeat tick.
`ifdef KEY_EVENT_REPEAT_EN
    assign cnt_clr_s = (state_nxt_s != state_r) || rep_clr_s;
`else
    assign cnt_clr_s = (state_nxt_s != state_r);
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and pulse decode. Strobe events take priority over counter thresholds.
    always_comb begin
        state_nxt_s = state_r;
        short_nxt_s = 1'b0;
        long_nxt_s  = 1'b0;
        dbl_nxt_s   = 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
        rep_nxt_s   = 1'b0;
        rep_clr_s   = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (press_ev_s) begin
                    state_nxt_s = ST_PRESS1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PRESS1: begin
                if (release_ev_s) begin
                    state_nxt_s = ST_WAIT2;
                end else if (cnt_r == LONG_LAST) begin
                    long_nxt_s  = 1'b1;
                    state_nxt_s = ST_HELD;
                end else begin
                    state_nxt_s = ST_PRESS1;
                end
            end
            ST_HELD: begin
                if (release_ev_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HELD;
`ifdef KEY_EVENT_REPEAT_EN
                    if (cnt_r == REPEAT_LAST) begin
                        rep_nxt_s = 1'b1;
                        rep_clr_s = 1'b1;
                    end else begin
                        rep_nxt_s = 1'b0;
                        rep_clr_s = 1'b0;
                    end
`endif
                end
            end
            ST_WAIT2: begin
                if (press_ev_s) begin
                    state_nxt_s = ST_PRESS2;
                end else if (cnt_r == DCLICK_LAST) begin
                    short_nxt_s = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT2;
                end
            end
            ST_PRESS2: begin
                if (release_ev_s) begin
                    dbl_nxt_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r == LONG_LAST) begin
                    // A second press held this long becomes a long press. The double click is dropped.
                    long_nxt_s  = 1'b1;
                    state_nxt_s = ST_HELD;
                end else begin
                    state_nxt_s = ST_PRESS2;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Saturating cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
        end else if (cnt_clr_s) begin
            cnt_r <= CNT_ZERO;
        end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Registered event pulses and the held level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
            key_held     <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
            repeat_press <= 1'b0;
`endif
        end else begin
            short_press  <= short_nxt_s;
            long_press   <= long_nxt_s;
            double_click <= dbl_nxt_s;
`ifdef KEY_EVENT_REPEAT_EN
            repeat_press <= rep_nxt_s;
`endif
            if (press_ev_s) begin
                key_held <= 1'b1;
            end else if (release_ev_s) begin
                key_held <= 1'b0;
            end else begin
                key_held <= key_held;
            end
        end
    end

endmodule

// File: tb/tb_key_event.sv
// -----------------------------------------------------------------------------
// tb_key_event
//
// Self-checking bench for key_event (LONG_CNT=20, DCLICK_CNT=10, REPEAT_CNT=5).
// Each table record lists the strobe edges and levels of one gesture, plus the
// edge after which each pulse must appear (-1 = never). Edge 0 is the first
// edge after reset release.
// Expected outputs are queued when stimulus is driven and popped after the edge.
// -----------------------------------------------------------------------------
module tb_key_event;

    localparam int LONG_CNT   = 20;
    localparam int DCLICK_CNT = 10;
    localparam int REPEAT_CNT = 5;
    localparam int NONE       = 1 << 30;
    localparam int NVEC       = 9;

    logic clk = 1'b0;
    logic rst;
    logic key_flag;
    logic key_state;
    logic short_press;
    logic long_press;
    logic double_click;
    logic key_held;
    logic repeat_press;

    key_event #(
        .LONG_CNT   (LONG_CNT),
        .DCLICK_CNT (DCLICK_CNT),
        .REPEAT_CNT (REPEAT_CNT),
        .CNT_W      (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_flag     (key_flag),
        .key_state    (key_state),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_click (double_click),
`ifdef KEY_EVENT_REPEAT_EN
        .repeat_press (repeat_press),
`endif
        .key_held     (key_held)
    );

`ifndef KEY_EVENT_REPEAT_EN
    assign repeat_press = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         se [6];   // strobe edges, -1 = unused slot
        logic [0:5] sl;       // strobe levels, 0 = press, 1 = release
        int         es;       // edge after which short_press is high
        int         el;       // edge after which long_press is high
        int         ed;       // edge after which double_click is high
        int         len;      // edges to run
    } vec_t;

    vec_t       vecs [NVEC];
    logic [4:0] exp_q [$];
    int         n_checks = 0;
    int         n_pass   = 0;

    // Output order in every compare: short, long, double, held, repeat.
    task automatic check(input string name, input int e, input logic [4:0] exp);
        logic [4:0] got;
        got = {short_press, long_press, double_click, key_held, repeat_press};
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s edge %0d: got s/l/d/h/r=%b, required %b", name, e, got, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        key_flag  = 1'b0;
        key_state = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", -1, 5'b00000);
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic       held;
        logic       rep;
        int         rel_after;
        logic [4:0] exp;
        held      = 1'b0;
        rel_after = NONE;
        // The first release after the long press ends the repeat train.
        if (v.el >= 0) begin
            for (int i = 0; i < 6; i++) begin
                if (v.se[i] > v.el && v.sl[i] && rel_after == NONE) rel_after = v.se[i];
            end
        end
        for (int e = 0; e < v.len; e++) begin
            key_flag = 1'b0;
            for (int i = 0; i < 6; i++) begin
                if (v.se[i] == e) begin
                    key_flag  = 1'b1;
                    key_state = v.sl[i];
                    held      = ~v.sl[i];
                end
            end
`ifdef KEY_EVENT_REPEAT_EN
            rep = (v.el >= 0) && (e > v.el) && (((e - v.el) % REPEAT_CNT) == 0) && (e < rel_after);
`else
            rep = 1'b0;
`endif
            exp = {(e == v.es), (e == v.el), (e == v.ed), held, rep};
            exp_q.push_back(exp);
            @(posedge clk);
            #1;
            check(v.name, e, exp_q.pop_front());
        end
        key_flag = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        key_flag  = 1'b0;
        key_state = 1'b1;

        vecs[0] = '{"short",         '{0, 5, -1, -1, -1, -1}, 6'b010000, 15, -1, -1, 25};
        vecs[1] = '{"long",          '{0, 40, -1, -1, -1, -1}, 6'b010000, -1, 20, -1, 50};
        vecs[2] = '{"double",        '{0, 3, 9, 12, -1, -1},  6'b010100, -1, -1, 12, 30};
        vecs[3] = '{"window_edge",   '{0, 5, 15, 18, -1, -1}, 6'b010100, -1, -1, 18, 35};
        vecs[4] = '{"rel_before_thr",'{0, 19, -1, -1, -1, -1}, 6'b010000, 29, -1, -1, 40};
        vecs[5] = '{"rel_at_thr",    '{0, 20, -1, -1, -1, -1}, 6'b010000, 30, -1, -1, 40};
        vecs[6] = '{"press2_long",   '{0, 3, 6, 40, -1, -1},  6'b010100, -1, 26, -1, 50};
        vecs[7] = '{"redundant",     '{0, 2, 4, 6, 8, -1},    6'b100110, 16, -1, -1, 25};
        vecs[8] = '{"held_press",    '{0, 25, 30, -1, -1, -1}, 6'b001000, -1, 20, -1, 40};

        for (int k = 0; k < NVEC; k++) begin
            do_reset();
            run_vec(vecs[k]);
        end

        // Reset in the middle of a press: outputs clear without a clock edge,
        // and no long press appears after reset releases.
        do_reset();
        key_flag  = 1'b1;
        key_state = 1'b0;
        @(posedge clk);
        #1;
        key_flag = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("held_before_rst", 9, 5'b00010);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_clear", 10, 5'b00000);
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        key_state = 1'b1;
        for (int e = 0; e < 30; e++) begin
            exp_q.push_back(5'b00000);
            @(posedge clk);
            #1;
            check("post_rst_quiet", e, exp_q.pop_front());
        end
        // A fresh gesture is handled normally after the aborted one.
        run_vec(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
